tpuv2: RTL and testbench
========================

# tpuv2

Parametrised, memory-mapped matrix-multiply accelerator top level, successor to the first-generation TPU wrapper. It wraps the existing `systolic_array`, `memA` and `memB` behind the single-port `r_w`/`addr`/`dataIn`/`dataOut` bus. It generalises row packing to any `DIM`/`DATAW` ratio through multi-beat staging, and sequences compute with an explicit FSM. It adds an optional C-clear before compute, a readable status/count register, a done pulse, and registered read data.

## Interface
- `BITS_AB`, 8: A/B element width (signed).
- `BITS_C`, 16: C element width (signed).
- `DIM`, 8: array dimension; power of two, ≥2.
- `ADDRW`, 16: byte-address width; ≥12.
- `DATAW`, 64: bus width; `DIM*BITS_AB` and `DIM*BITS_C` are integer multiples of it.
- `clk`  in  1  the only clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low; also drives the sub-module resets.
- `r_w`  in  1  0 = read, 1 = write; qualifies `addr` every cycle.
- `addr`  in  `ADDRW`  byte address. `addr[11:8]` is the region; lower bits are row/beat.
- `dataIn`  in  `DATAW`  write data.
- `dataOut`  out  `DATAW`  registered read data; reset 0.
- `done`  out  1  one-cycle pulse when a compute finishes; reset 0.

## Operation
- Derived constants:
  - `BYTEOFF = log2(DATAW/8)`.
  - `ABEATS = DIM*BITS_AB/DATAW` and `CBEATS = DIM*BITS_C/DATAW`.
  - `ABB`/`CBB` = log2 of the beat count (0 means a single beat, no beat field).
- A/B beat index is `addr[BYTEOFF +: ABB]`. A row is `addr[BYTEOFF+ABB +: log2 DIM]`.
- C beat index is `addr[BYTEOFF +: CBB]`. C row is `addr[BYTEOFF+CBB +: log2 DIM]`.
- Beat b carries elements `b*DATAW/width ..`, with the lowest element in the lowest bits.
- Region 1, A write: the beat is stored into the A staging row. On the last beat, the row is committed to `memA` at the addressed row with `WrEn`.
- Region 2, B write: same staging scheme. On the last beat, the row is committed by pulsing `memB` `en` for one cycle.
- Region 3, C write: the beat is staged. On the last beat, the row is written with `systolic_array` `WrEn`/`Crow`; elements of non-written beats come from a C staging buffer, not from `Cout`.
- Region 3, C read: `dataOut` is loaded with the addressed beat of the addressed `Cout` row.
- Region 4 write, start: `dataIn[0]=1` requests a clear-before-compute. Ignored unless IDLE.
- Region 5 read, status register, zero-extended into `dataOut`:
  - bit0: busy.
  - bit1: done_sticky.
  - bit2: err.
  - [31:16]: completed-compute count (wraps at 2^16).
  - Reading status clears done_sticky and err.
- Other regions: writes are ignored; reads return 0.
- FSM states:
  - IDLE: start moves to CLEAR if `dataIn[0]`, else RUN.
  - CLEAR: `DIM` cycles; writes zeros to C rows 0..DIM-1 in order, then moves to RUN.
  - RUN: `3*DIM` cycles with `en` asserted to `memA`, `memB` and `systolic_array`, then moves to FIN.
  - FIN: one cycle; pulses `done`, sets done_sticky, increments the count, then moves to IDLE.
- While not IDLE:
  - Region 1–3 writes and region 4 are dropped and set err.
  - C reads return 0 and set err.
  - Status reads are always served.
- Start also clears done_sticky and discards partial staging.

## Timing
- Read latency is 1 cycle: the address is presented in cycle t and `dataOut` is valid in t+1. It holds until the next read; writes do not change it.
- Row commit happens in the same cycle as the last beat, so it is visible to a C read issued the following cycle.
- Start written in cycle t:
  - busy=1 from t+1.
  - Without clear, `done` is high in cycle t+1+3*DIM and busy=0 in t+2+3*DIM.
  - Clear adds `DIM` cycles.
- Beats may arrive in any order and be repeated; commit is triggered only by the last-beat index. A different row address on a later beat retargets the commit.
- Reset, including during CLEAR/RUN: returns to IDLE and clears all staging, the count, status bits, `dataOut` and `done`. Sub-module contents follow their own reset.
- A start write in the FIN cycle is dropped with err.
- A status read in the cycle done_sticky is set: returns the pre-set value, and the set wins.

## Structure
- `tpuv2_pkg` holds:
  - the region code constants (1–5);
  - the FSM state enum (IDLE, CLEAR, RUN, FIN);
  - status bit-position constants;
  - a function returning the beat/row field widths.
- Sub-module `tpuv2_seq`: the FSM, cycle counter, clear-row counter, done/count/status logic. The top keeps bus decode, staging and sub-module instances.

## Test plan
- Reset hold for 3 cycles, then a status read: `dataOut` = 0 one cycle later and `done`=0.
- Defaults:
  - Write A = identity (row r byte r = 1) and 8 B rows with B[i][j] = i+j.
  - Start with `dataIn`=1.
  - Required: `done` exactly 32 cycles after the start (8 CLEAR + 24 RUN).
  - Required: C reads return the expected A×B values.
  - Required: status = 0x0001_0002.
- C write: row 5 beat 0 = 0x0004_0003_0002_0001 and beat 1 = 0x0008_0007_0006_0005. Required: reading back row 5 returns the same beats with 1-cycle latency.
- A write during RUN: memA is unchanged after the run and the status read shows err=1. A second status read shows err=0.
- Reset asserted mid-RUN: `done` never pulses, and a status read returns 0.
- DATAW=32: A rows take 2 beats, out of order (beat 1 then beat 0). Required: the commit happens only after beat 1, and the compute result matches the 64-bit build.

Source files
------------

// File: rtl/tpuv2_pkg.sv
// Shared constants, FSM state type and field-width helper for the tpuv2 accelerator.
package tpuv2_pkg;

  localparam logic [3:0] REG_A      = 4'd1;
  localparam logic [3:0] REG_B      = 4'd2;
  localparam logic [3:0] REG_C      = 4'd3;
  localparam logic [3:0] REG_START  = 4'd4;
  localparam logic [3:0] REG_STATUS = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_FIN
  } state_e;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_ERR     = 2;
  localparam int unsigned STAT_CNT_LSB = 16;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned STATUS_W     = 32;

  // Width of an address field selecting one of total/unit items (0 when only one item).
  function automatic int unsigned field_w(input int unsigned total, input int unsigned unit);
    return $clog2(total / unit);
  endfunction

endpackage

// File: rtl/memA.sv
// Matrix A store: random-access row writes, streams one column per enabled cycle.
module memA #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       WrEn,
  input  logic [$clog2(DIM)-1:0]     Arow,
  input  logic [DIM*BITS_AB-1:0]     Ain,
  output logic [DIM*BITS_AB-1:0]     Aout
);
  localparam int unsigned LDIM = $clog2(DIM);

  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] mem_q;
  logic [DIM-1:0][BITS_AB-1:0]          aout_v;
  logic [LDIM:0]                        k_q;

  // Row writes and column index; the index rewinds whenever streaming stops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
      k_q   <= '0;
    end else begin
      if (WrEn) mem_q[Arow] <= Ain;
      if (en) begin
        if (!k_q[LDIM]) k_q <= k_q + 1'b1;
      end else begin
        k_q <= '0;
      end
    end
  end

  // Column k of A, zero once all columns have been streamed.
  always_comb begin
    aout_v = '0;
    for (int i = 0; i < int'(DIM); i++) begin
      if (!k_q[LDIM]) aout_v[i] = mem_q[i][k_q[LDIM-1:0]];
    end
  end

  assign Aout = aout_v;

endmodule

// File: rtl/memB.sv
// Matrix B store: rows shift in on en, row 0 is presented to the array.
module memB #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [DIM*BITS_AB-1:0] Bin,
  output logic [DIM*BITS_AB-1:0] Bout
);
  logic [DIM-1:0][DIM*BITS_AB-1:0] rows_q;

  // Shift register of rows; new rows enter at the top.
  always_ff @(posedge clk) begin
    if (!rst_n) rows_q <= '0;
    else if (en) rows_q <= {Bin, rows_q[DIM-1:1]};
  end

  assign Bout = rows_q[0];

endmodule

// File: rtl/systolic_array.sv
// Output-stationary MAC grid: C += column(A) x row(B) per enabled cycle, row-writable.
module systolic_array #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned BITS_C  = 16,
  parameter int unsigned DIM     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       WrEn,
  input  logic [$clog2(DIM)-1:0]     Crow,
  input  logic [DIM*BITS_C-1:0]      Cin,
  input  logic [DIM*BITS_AB-1:0]     Ain,
  input  logic [DIM*BITS_AB-1:0]     Bin,
  output logic [DIM*DIM*BITS_C-1:0]  Cout
);
  logic [DIM-1:0][DIM-1:0][BITS_C-1:0] c_q;
  logic [DIM-1:0][BITS_AB-1:0]         a_v;
  logic [DIM-1:0][BITS_AB-1:0]         b_v;

  assign a_v  = Ain;
  assign b_v  = Bin;
  assign Cout = c_q;

  // Signed accumulate while enabled; host row writes when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q <= '0;
    end else begin
      if (en) begin
        for (int i = 0; i < int'(DIM); i++) begin
          for (int j = 0; j < int'(DIM); j++) begin
            c_q[i][j] <= c_q[i][j] + BITS_C'(signed'(a_v[i])) * BITS_C'(signed'(b_v[j]));
          end
        end
      end
      if (WrEn) c_q[Crow] <= Cin;
    end
  end

endmodule

// File: rtl/tpuv2_seq.sv
// Compute sequencer: FSM, phase counter, clear-row walk, done pulse and status bits.
module tpuv2_seq
  import tpuv2_pkg::*;
#(
  parameter int unsigned DIM = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   start_clr,
  input  logic                   status_rd,
  input  logic                   err_evt,
  output logic                   busy_c,
  output logic                   clear_we_c,
  output logic                   run_en_c,
  output logic [$clog2(DIM)-1:0] clear_row,
  output logic                   done,
  output logic [STATUS_W-1:0]    status_c
);
  localparam int unsigned LDIM = $clog2(DIM);
  localparam int unsigned CW   = $clog2(3 * DIM);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_d;
  logic             sticky_q, sticky_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;

  // State and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done     <= 1'b0;
      sticky_q <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done     <= done_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // Next state, counters and status updates; sets take priority over read-clears.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    sticky_d   = sticky_q;
    err_d      = err_q;
    count_d    = count_q;
    busy_c     = (state_q != ST_IDLE);
    clear_we_c = (state_q == ST_CLEAR);
    run_en_c   = (state_q == ST_RUN);

    if (status_rd) begin
      sticky_d = 1'b0;
      err_d    = 1'b0;
    end
    if (err_evt) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = start_clr ? ST_CLEAR : ST_RUN;
          cnt_d    = '0;
          sticky_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CW'(DIM - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(3 * DIM - 1)) begin
          state_d = ST_FIN;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIN: begin
        state_d  = ST_IDLE;
        sticky_d = 1'b1;
        count_d  = count_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clear_row = cnt_q[LDIM-1:0];

  // Status word layout.
  always_comb begin
    status_c                           = '0;
    status_c[STAT_BUSY]                = busy_c;
    status_c[STAT_DONE]                = sticky_q;
    status_c[STAT_ERR]                 = err_q;
    status_c[STAT_CNT_LSB +: CNT_W]    = count_q;
  end

endmodule

// File: rtl/tpuv2.sv
// Memory-mapped matrix-multiply accelerator: bus decode, beat staging, sub-module wiring.
module tpuv2
  import tpuv2_pkg::*;
#(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned BITS_C  = 16,
  parameter int unsigned DIM     = 8,
  parameter int unsigned ADDRW   = 16,
  parameter int unsigned DATAW   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r_w,
  input  logic [ADDRW-1:0] addr,
  input  logic [DATAW-1:0] dataIn,
  output logic [DATAW-1:0] dataOut,
  output logic             done
);
  localparam int unsigned BYTEOFF = field_w(DATAW, 8);
  localparam int unsigned ROWA    = DIM * BITS_AB;
  localparam int unsigned ROWC    = DIM * BITS_C;
  localparam int unsigned ABEATS  = ROWA / DATAW;
  localparam int unsigned CBEATS  = ROWC / DATAW;
  localparam int unsigned ABB     = field_w(ROWA, DATAW);
  localparam int unsigned CBB     = field_w(ROWC, DATAW);
  localparam int unsigned ABW     = (ABB == 0) ? 1 : ABB;
  localparam int unsigned CBW     = (CBB == 0) ? 1 : CBB;
  localparam int unsigned LDIM    = field_w(DIM, 1);

  logic [3:0]      region;
  logic [ABW-1:0]  ab_beat;
  logic [CBW-1:0]  c_beat;
  logic [LDIM-1:0] ab_row;
  logic [LDIM-1:0] c_row;

  logic busy, clear_we, run_en, start, start_go, status_rd, err_evt;
  logic a_wr, b_wr, c_wr, a_commit, b_commit, c_commit;
  logic [LDIM-1:0]     clear_row;
  logic [STATUS_W-1:0] status;

  logic [ABEATS-1:0][DATAW-1:0] a_stage, a_merged, b_stage, b_merged;
  logic [CBEATS-1:0][DATAW-1:0] c_stage, c_merged;
  logic [DIM-1:0][CBEATS-1:0][DATAW-1:0] c_view;
  logic [DIM*DIM*BITS_C-1:0] cout;
  logic [ROWA-1:0]           a_col, b_row_out, b_in;
  logic [LDIM-1:0]           sa_row;
  logic [ROWC-1:0]           sa_cin;

  // Address field decode.
  assign region  = addr[11:8];
  assign ab_beat = (ABB == 0) ? '0 : ABW'(addr >> BYTEOFF);
  assign c_beat  = (CBB == 0) ? '0 : CBW'(addr >> BYTEOFF);
  assign ab_row  = LDIM'(addr >> (BYTEOFF + ABB));
  assign c_row   = LDIM'(addr >> (BYTEOFF + CBB));

  // Bus command classification.
  assign a_wr      = r_w && (region == REG_A);
  assign b_wr      = r_w && (region == REG_B);
  assign c_wr      = r_w && (region == REG_C);
  assign start     = r_w && (region == REG_START);
  assign start_go  = start && !busy;
  assign status_rd = !r_w && (region == REG_STATUS);
  assign err_evt   = busy && ((r_w && (region >= REG_A) && (region <= REG_START)) ||
                              (!r_w && (region == REG_C)));
  assign a_commit  = a_wr && !busy && (ab_beat == ABW'(ABEATS - 1));
  assign b_commit  = b_wr && !busy && (ab_beat == ABW'(ABEATS - 1));
  assign c_commit  = c_wr && !busy && (c_beat == CBW'(CBEATS - 1));

  // Full rows as they would look with the current beat folded in.
  always_comb begin
    a_merged          = a_stage;
    a_merged[ab_beat] = dataIn;
    b_merged          = b_stage;
    b_merged[ab_beat] = dataIn;
    c_merged          = c_stage;
    c_merged[c_beat]  = dataIn;
  end

  // Beat staging; a start discards any partial rows.
  always_ff @(posedge clk) begin
    if (!rst_n || start_go) begin
      a_stage <= '0;
      b_stage <= '0;
      c_stage <= '0;
    end else if (!busy) begin
      if (a_wr) a_stage[ab_beat] <= dataIn;
      if (b_wr) b_stage[ab_beat] <= dataIn;
      if (c_wr) c_stage[c_beat]  <= dataIn;
    end
  end

  // Registered read data; C reads while busy return zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dataOut <= '0;
    end else if (!r_w) begin
      case (region)
        REG_C:      dataOut <= busy ? '0 : c_view[c_row][c_beat];
        REG_STATUS: dataOut <= DATAW'(status);
        default:    dataOut <= '0;
      endcase
    end
  end

  assign c_view = cout;
  assign b_in   = b_commit ? b_merged : '0;
  assign sa_row = clear_we ? clear_row : c_row;
  assign sa_cin = clear_we ? '0 : c_merged;

  tpuv2_seq #(.DIM(DIM)) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_clr  (dataIn[0]),
    .status_rd  (status_rd),
    .err_evt    (err_evt),
    .busy_c     (busy),
    .clear_we_c (clear_we),
    .run_en_c   (run_en),
    .clear_row  (clear_row),
    .done       (done),
    .status_c   (status)
  );

  memA #(.BITS_AB(BITS_AB), .DIM(DIM)) u_mem_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_en),
    .WrEn  (a_commit),
    .Arow  (ab_row),
    .Ain   (a_merged),
    .Aout  (a_col)
  );

  memB #(.BITS_AB(BITS_AB), .DIM(DIM)) u_mem_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_en || b_commit),
    .Bin   (b_in),
    .Bout  (b_row_out)
  );

  systolic_array #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_en),
    .WrEn  (c_commit || clear_we),
    .Crow  (sa_row),
    .Cin   (sa_cin),
    .Ain   (a_col),
    .Bin   (b_row_out),
    .Cout  (cout)
  );

endmodule

// File: tb/tb_tpuv2.sv
// Directed bench for tpuv2: 64-bit default build plus a 32-bit bus build.
module tb_tpuv2;
  logic        clk;
  logic        rst_n;
  logic        r_w, r_w32;
  logic [15:0] addr, addr32;
  logic [63:0] data_in, data_out;
  logic [31:0] data_in32, data_out32;
  logic        done, done32;

  int vectors = 0;
  int miscompares = 0;

  tpuv2 u_dut (
    .clk(clk), .rst_n(rst_n), .r_w(r_w), .addr(addr),
    .dataIn(data_in), .dataOut(data_out), .done(done)
  );

  tpuv2 #(.DATAW(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .r_w(r_w32), .addr(addr32),
    .dataIn(data_in32), .dataOut(data_out32), .done(done32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit s, input logic [15:0] a, input logic [63:0] d);
    if (s) begin r_w32 = 1'b1; addr32 = a; data_in32 = d[31:0]; end
    else   begin r_w = 1'b1; addr = a; data_in = d; end
    tick();
    r_w = 1'b0; addr = '0; r_w32 = 1'b0; addr32 = '0;
  endtask

  task automatic rd(input bit s, input logic [15:0] a, output logic [63:0] q);
    if (s) begin r_w32 = 1'b0; addr32 = a; end
    else   begin r_w = 1'b0; addr = a; end
    tick();
    q = s ? 64'(data_out32) : data_out;
    addr = '0; addr32 = '0;
  endtask

  task automatic wait_done(input bit s, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      tick();
      n++;
      if ((s ? done32 : done) === 1'b1) break;
    end
  endtask

  function automatic logic [15:0] a64(input int r);
    return 16'h0100 | 16'(r << 3);
  endfunction
  function automatic logic [15:0] b64(input int r);
    return 16'h0200 | 16'(r << 3);
  endfunction
  function automatic logic [15:0] c64(input int r, input int b);
    return 16'h0300 | 16'(r << 4) | 16'(b << 3);
  endfunction
  function automatic logic [15:0] ab32(input logic [15:0] base, input int r, input int b);
    return base | 16'(r << 3) | 16'(b << 2);
  endfunction
  function automatic logic [15:0] c32(input int r, input int b);
    return 16'h0300 | 16'(r << 4) | 16'(b << 2);
  endfunction

  function automatic logic [63:0] ident_row(input int r);
    logic [63:0] v;
    v = '0;
    v[8*r +: 8] = 8'd1;
    return v;
  endfunction
  function automatic logic [63:0] b_row(input int i);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < 8; j++) v[8*j +: 8] = 8'(i + j);
    return v;
  endfunction
  // C = I x B = B, so C[r][e] = r + e; beat of width w holds elements b*w/16 upward.
  function automatic logic [63:0] c_exp(input int r, input int b, input int per_beat);
    logic [63:0] v;
    v = '0;
    for (int e = 0; e < per_beat; e++) v[16*e +: 16] = 16'(r + b * per_beat + e);
    return v;
  endfunction

  initial begin
    logic [63:0] q;
    int n;
    bit seen;

    rst_n = 1'b0;
    r_w = 1'b0; addr = '0; data_in = '0;
    r_w32 = 1'b0; addr32 = '0; data_in32 = '0;
    repeat (3) tick();
    check("reset_dataout", data_out, 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    rd(0, 16'h0500, q);
    check("reset_status", q, 64'd0);
    check("reset_done_after", 64'(done), 64'd0);

    // Identity A, B[i][j] = i+j, start with clear.
    for (int r = 0; r < 8; r++) wr(0, a64(r), ident_row(r));
    for (int i = 0; i < 8; i++) wr(0, b64(i), b_row(i));
    wr(0, 16'h0400, 64'd1);
    wait_done(0, 100, n);
    check("done_latency_clear", 64'(n), 64'd32);
    tick();
    check("done_is_pulse", 64'(done), 64'd0);
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < 2; b++) begin
        rd(0, c64(r, b), q);
        check($sformatf("c_row%0d_beat%0d", r, b), q, c_exp(r, b, 4));
      end
    end
    rd(0, 16'h0500, q);
    check("status_after_run", q, 64'h0001_0002);
    rd(0, 16'h0500, q);
    check("status_reread", q, 64'h0001_0000);

    // C row write and read-back, plus read-data hold across a write.
    wr(0, c64(5, 0), 64'h0004_0003_0002_0001);
    wr(0, c64(5, 1), 64'h0008_0007_0006_0005);
    rd(0, c64(5, 0), q);
    check("cwr_beat0", q, 64'h0004_0003_0002_0001);
    r_w = 1'b0; addr = c64(5, 1);
    tick();
    check("cwr_beat1", data_out, 64'h0008_0007_0006_0005);
    r_w = 1'b1; addr = 16'h0000; data_in = 64'hDEAD_BEEF_0000_0000;
    tick();
    check("dataout_hold_on_write", data_out, 64'h0008_0007_0006_0005);
    r_w = 1'b0; addr = '0;

    // Run without clear; C read and A write during RUN are dropped with err.
    wr(0, 16'h0400, 64'd0);
    rd(0, 16'h0500, q);
    check("status_busy", q, 64'h0001_0001);
    rd(0, c64(0, 0), q);
    check("c_read_busy", q, 64'd0);
    wr(0, a64(0), 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(0, 100, n);
    check("done_latency_noclear", 64'(n + 3), 64'd24);
    tick();
    rd(0, 16'h0500, q);
    check("status_err", q, 64'h0002_0006);
    rd(0, 16'h0500, q);
    check("status_err_cleared", q, 64'h0002_0000);
    for (int i = 0; i < 8; i++) wr(0, b64(i), b_row(i));
    wr(0, 16'h0400, 64'd1);
    wait_done(0, 100, n);
    check("done_latency_rerun", 64'(n), 64'd32);
    tick();
    rd(0, c64(0, 0), q);
    check("mema_unchanged_r0b0", q, c_exp(0, 0, 4));
    rd(0, c64(7, 1), q);
    check("mema_unchanged_r7b1", q, c_exp(7, 1, 4));

    // Reset in the middle of RUN.
    wr(0, 16'h0400, 64'd0);
    repeat (5) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    check("midrun_reset_dataout", data_out, 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    check("midrun_no_done", 64'(seen), 64'd0);
    rd(0, 16'h0500, q);
    check("midrun_status", q, 64'd0);

    // 32-bit bus: A rows in two beats, high beat first, then low, then high again.
    for (int r = 0; r < 8; r++) begin
      wr(1, ab32(16'h0100, r, 1), ident_row(r) >> 32);
      wr(1, ab32(16'h0100, r, 0), ident_row(r));
      wr(1, ab32(16'h0100, r, 1), ident_row(r) >> 32);
    end
    wr(1, ab32(16'h0100, 0, 0), 64'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      wr(1, ab32(16'h0200, i, 0), b_row(i));
      wr(1, ab32(16'h0200, i, 1), b_row(i) >> 32);
    end
    wr(1, 16'h0400, 64'd1);
    wait_done(1, 100, n);
    check("d32_done_latency", 64'(n), 64'd32);
    tick();
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < 4; b++) begin
        rd(1, c32(r, b), q);
        check($sformatf("d32_c_row%0d_beat%0d", r, b), q, c_exp(r, b, 2));
      end
    end
    rd(1, 16'h0500, q);
    check("d32_status", q, 64'h0001_0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
